// File: rtl/mem_port_responder.sv
// Serialises the fetch port (A) and data port (B) onto one physical memory port.
// Latency: strobe the cycle after the IDLE sample, joint response the cycle after the last pmem_resp.
// Backpressure: requests are latched once in IDLE and then ignored until the next IDLE sample.
module mem_port_responder #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_read_a,
  input  logic [ADDR_W-1:0] mem_address_a,
  output logic              mem_resp_a,
  output logic [DATA_W-1:0] mem_rdata_a,
  input  logic              mem_read_b,
  input  logic              mem_write_b,
  input  logic [1:0]        mem_wmask_b,
  input  logic [ADDR_W-1:0] mem_address_b,
  input  logic [DATA_W-1:0] mem_wdata_b,
  output logic              mem_resp_b,
  output logic [DATA_W-1:0] mem_rdata_b,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [1:0]        pmem_wmask,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [DATA_W-1:0] pmem_wdata,
  input  logic              pmem_resp,
  input  logic [DATA_W-1:0] pmem_rdata
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    B_ACCESS = 2'd1,
    A_ACCESS = 2'd2,
    RESPOND  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              need_a_q, need_a_d;
  logic              need_b_q, need_b_d;
  logic              op_b_q, op_b_d;          // 1 = write
  logic [ADDR_W-1:0] addr_a_q, addr_a_d;
  logic [ADDR_W-1:0] addr_b_q, addr_b_d;
  logic [DATA_W-1:0] wdata_b_q, wdata_b_d;
  logic [1:0]        wmask_b_q, wmask_b_d;
  logic [DATA_W-1:0] rdata_a_q, rdata_a_d;
  logic [DATA_W-1:0] rdata_b_q, rdata_b_d;

  assign mem_rdata_a = rdata_a_q;
  assign mem_rdata_b = rdata_b_q;

  // State and latched request registers; reset abandons any access in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      need_a_q  <= 1'b0;
      need_b_q  <= 1'b0;
      op_b_q    <= 1'b0;
      addr_a_q  <= '0;
      addr_b_q  <= '0;
      wdata_b_q <= '0;
      wmask_b_q <= '0;
      rdata_a_q <= '0;
      rdata_b_q <= '0;
    end else begin
      state_q   <= state_d;
      need_a_q  <= need_a_d;
      need_b_q  <= need_b_d;
      op_b_q    <= op_b_d;
      addr_a_q  <= addr_a_d;
      addr_b_q  <= addr_b_d;
      wdata_b_q <= wdata_b_d;
      wmask_b_q <= wmask_b_d;
      rdata_a_q <= rdata_a_d;
      rdata_b_q <= rdata_b_d;
    end
  end

  // Next-state and output decode; data port is served first as it is older in program order.
  always_comb begin
    state_d      = state_q;
    need_a_d     = need_a_q;
    need_b_d     = need_b_q;
    op_b_d       = op_b_q;
    addr_a_d     = addr_a_q;
    addr_b_d     = addr_b_q;
    wdata_b_d    = wdata_b_q;
    wmask_b_d    = wmask_b_q;
    rdata_a_d    = rdata_a_q;
    rdata_b_d    = rdata_b_q;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_wmask   = 2'b00;
    pmem_address = '0;
    pmem_wdata   = '0;
    mem_resp_a   = 1'b0;
    mem_resp_b   = 1'b0;

    case (state_q)
      IDLE: begin
        need_a_d  = mem_read_a;
        need_b_d  = mem_read_b | mem_write_b;
        op_b_d    = mem_write_b;             // write wins over a simultaneous read
        addr_a_d  = mem_address_a;
        addr_b_d  = mem_address_b;
        wdata_b_d = mem_wdata_b;
        wmask_b_d = mem_wmask_b;
        if (mem_read_b | mem_write_b) begin
          state_d = B_ACCESS;
        end else if (mem_read_a) begin
          state_d = A_ACCESS;
        end
      end
      B_ACCESS: begin
        pmem_read    = ~op_b_q;
        pmem_write   = op_b_q;
        pmem_address = addr_b_q;
        pmem_wdata   = wdata_b_q;
        pmem_wmask   = op_b_q ? wmask_b_q : 2'b11;
        if (pmem_resp) begin
          if (!op_b_q) begin
            rdata_b_d = pmem_rdata;
          end
          state_d = need_a_q ? A_ACCESS : RESPOND;
        end
      end
      A_ACCESS: begin
        pmem_read    = 1'b1;
        pmem_address = addr_a_q;
        pmem_wmask   = 2'b11;
        if (pmem_resp) begin
          rdata_a_d = pmem_rdata;
          state_d   = RESPOND;
        end
      end
      RESPOND: begin
        mem_resp_a = need_a_q;
        mem_resp_b = need_b_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_port_responder.sv
// Directed bench for mem_port_responder with a small wait-state pmem model.
// Checks are taken 1 time unit after each rising edge.
// The pmem model answers after wait_n extra cycles with rd0 then rd1 per transaction.
module tb_mem_port_responder;

  logic        clk;
  logic        rst_n;
  logic        mem_read_a;
  logic [15:0] mem_address_a;
  logic        mem_resp_a;
  logic [15:0] mem_rdata_a;
  logic        mem_read_b;
  logic        mem_write_b;
  logic [1:0]  mem_wmask_b;
  logic [15:0] mem_address_b;
  logic [15:0] mem_wdata_b;
  logic        mem_resp_b;
  logic [15:0] mem_rdata_b;
  logic        pmem_read;
  logic        pmem_write;
  logic [1:0]  pmem_wmask;
  logic [15:0] pmem_address;
  logic [15:0] pmem_wdata;
  logic        pmem_resp;
  logic [15:0] pmem_rdata;

  int          n_checks;
  int          n_errors;

  // pmem model controls
  int          wait_n;
  int          wcnt;
  int          acc_idx;
  logic [15:0] rd0, rd1;
  logic        extra_resp;

  mem_port_responder #(.DATA_W(16), .ADDR_W(16)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .mem_read_a    (mem_read_a),
    .mem_address_a (mem_address_a),
    .mem_resp_a    (mem_resp_a),
    .mem_rdata_a   (mem_rdata_a),
    .mem_read_b    (mem_read_b),
    .mem_write_b   (mem_write_b),
    .mem_wmask_b   (mem_wmask_b),
    .mem_address_b (mem_address_b),
    .mem_wdata_b   (mem_wdata_b),
    .mem_resp_b    (mem_resp_b),
    .mem_rdata_b   (mem_rdata_b),
    .pmem_read     (pmem_read),
    .pmem_write    (pmem_write),
    .pmem_wmask    (pmem_wmask),
    .pmem_address  (pmem_address),
    .pmem_wdata    (pmem_wdata),
    .pmem_resp     (pmem_resp),
    .pmem_rdata    (pmem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign pmem_resp  = extra_resp | ((pmem_read | pmem_write) && (wcnt == wait_n));
  assign pmem_rdata = (acc_idx == 0) ? rd0 : rd1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt    <= 0;
      acc_idx <= 0;
    end else if (mem_resp_a | mem_resp_b) begin
      wcnt    <= 0;
      acc_idx <= 0;
    end else if (pmem_read | pmem_write) begin
      if (wcnt == wait_n) begin
        wcnt    <= 0;
        acc_idx <= acc_idx + 1;
      end else begin
        wcnt <= wcnt + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    mem_read_a    = 1'b0;
    mem_read_b    = 1'b0;
    mem_write_b   = 1'b0;
    mem_wmask_b   = 2'b00;
    mem_address_a = 16'h0;
    mem_address_b = 16'h0;
    mem_wdata_b   = 16'h0;
  endtask

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    wait_n     = 0;
    rd0        = 16'h0;
    rd1        = 16'h0;
    extra_resp = 1'b0;
    idle_inputs();
    rst_n = 1'b0;
    step();
    step();
    check("rst pmem_read", pmem_read, 1'b0);
    check("rst pmem_write", pmem_write, 1'b0);
    check("rst pmem_addr", pmem_address, 16'h0);
    check("rst resp_a", mem_resp_a, 1'b0);
    check("rst rdata_a", mem_rdata_a, 16'h0);
    check("rst rdata_b", mem_rdata_b, 16'h0);
    rst_n = 1'b1;

    // Reset in the middle of a B read
    wait_n = 3;
    mem_read_b = 1'b1; mem_address_b = 16'h2222;
    step();
    check("mid pmem_read", pmem_read, 1'b1);
    check("mid pmem_addr", pmem_address, 16'h2222);
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check("async pmem_read", pmem_read, 1'b0);
    check("async pmem_addr", pmem_address, 16'h0);
    idle_inputs();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("post-rst resp", {mem_resp_a, mem_resp_b}, 2'b00);
      check("post-rst strobe", {pmem_read, pmem_write}, 2'b00);
    end

    // A-only read, zero wait
    wait_n = 0; rd0 = 16'h1234;
    mem_read_a = 1'b1; mem_address_a = 16'h0040;
    check("A c0 pmem_read", pmem_read, 1'b0);
    step();
    check("A c1 pmem_read", pmem_read, 1'b1);
    check("A c1 addr", pmem_address, 16'h0040);
    check("A c1 wmask", pmem_wmask, 2'b11);
    check("A c1 resp_a", mem_resp_a, 1'b0);
    step();
    check("A c2 pmem_read", pmem_read, 1'b0);
    check("A c2 resp_a", mem_resp_a, 1'b1);
    check("A c2 resp_b", mem_resp_b, 1'b0);
    check("A c2 rdata_a", mem_rdata_a, 16'h1234);
    idle_inputs();
    step();
    check("A c3 resp_a", mem_resp_a, 1'b0);
    check("A c3 rdata_a held", mem_rdata_a, 16'h1234);

    // A + B reads, 2 wait cycles each
    wait_n = 2; rd0 = 16'hBEEF; rd1 = 16'h00AA;
    mem_read_a = 1'b1; mem_address_a = 16'h0010;
    mem_read_b = 1'b1; mem_address_b = 16'h2000;
    step();
    check("AB c1 addr", pmem_address, 16'h2000);
    check("AB c1 pmem_read", pmem_read, 1'b1);
    step();
    step();
    check("AB c3 addr held", pmem_address, 16'h2000);
    step();
    check("AB c4 addr", pmem_address, 16'h0010);
    check("AB c4 rdata_b", mem_rdata_b, 16'hBEEF);
    check("AB c4 resp", {mem_resp_a, mem_resp_b}, 2'b00);
    step();
    step();
    check("AB c6 rdata_a", mem_rdata_a, 16'h1234);
    step();
    check("AB c7 resp", {mem_resp_a, mem_resp_b}, 2'b11);
    check("AB c7 rdata_a", mem_rdata_a, 16'h00AA);
    check("AB c7 rdata_b", mem_rdata_b, 16'hBEEF);
    idle_inputs();
    step();
    check("AB c8 resp", {mem_resp_a, mem_resp_b}, 2'b00);

    // B write with mask plus A read
    wait_n = 0; rd0 = 16'hFFFF; rd1 = 16'h7777;
    mem_read_a = 1'b1; mem_address_a = 16'h0100;
    mem_write_b = 1'b1; mem_address_b = 16'h3002; mem_wdata_b = 16'h5A5A; mem_wmask_b = 2'b10;
    step();
    check("W c1 strobes", {pmem_read, pmem_write}, 2'b01);
    check("W c1 addr", pmem_address, 16'h3002);
    check("W c1 wdata", pmem_wdata, 16'h5A5A);
    check("W c1 wmask", pmem_wmask, 2'b10);
    step();
    check("W c2 strobes", {pmem_read, pmem_write}, 2'b10);
    check("W c2 addr", pmem_address, 16'h0100);
    check("W c2 wmask", pmem_wmask, 2'b11);
    check("W c2 rdata_b", mem_rdata_b, 16'hBEEF);
    step();
    check("W c3 resp", {mem_resp_a, mem_resp_b}, 2'b11);
    check("W c3 rdata_a", mem_rdata_a, 16'h7777);
    check("W c3 rdata_b", mem_rdata_b, 16'hBEEF);
    idle_inputs();
    step();

    // Read and write on B together, A address changes after latch
    wait_n = 1; rd0 = 16'h0000; rd1 = 16'h4321;
    mem_read_a = 1'b1; mem_address_a = 16'h0200;
    mem_read_b = 1'b1; mem_write_b = 1'b1; mem_address_b = 16'h4000;
    mem_wdata_b = 16'h1111; mem_wmask_b = 2'b01;
    step();
    check("RW c1 strobes", {pmem_read, pmem_write}, 2'b01);
    mem_address_a = 16'h0EEE;
    step();
    check("RW c2 strobes", {pmem_read, pmem_write}, 2'b01);
    step();
    check("RW c3 A addr", pmem_address, 16'h0200);
    step();
    check("RW c4 A addr", pmem_address, 16'h0200);
    step();
    check("RW c5 resp", {mem_resp_a, mem_resp_b}, 2'b11);
    check("RW c5 rdata_a", mem_rdata_a, 16'h4321);
    idle_inputs();
    step();

    // Back-to-back A reads held through RESPOND
    wait_n = 0; rd0 = 16'h0101;
    mem_read_a = 1'b1; mem_address_a = 16'h0050;
    step();
    check("BB c1 pmem_read", pmem_read, 1'b1);
    step();
    check("BB c2 resp_a", mem_resp_a, 1'b1);
    check("BB c2 rdata_a", mem_rdata_a, 16'h0101);
    step();
    check("BB c3 idle gap", pmem_read, 1'b0);
    rd0 = 16'h0202;
    step();
    check("BB c4 pmem_read", pmem_read, 1'b1);
    idle_inputs();
    step();
    check("BB c5 resp_a", mem_resp_a, 1'b1);
    check("BB c5 rdata_a", mem_rdata_a, 16'h0202);
    step();
    extra_resp = 1'b1; rd0 = 16'hDEAD;
    step();
    extra_resp = 1'b0;
    check("stray resp strobe", {pmem_read, pmem_write}, 2'b00);
    check("stray resp resp", {mem_resp_a, mem_resp_b}, 2'b00);
    check("stray resp rdata_a", mem_rdata_a, 16'h0202);
    step();

    // B-only write with empty mask is still issued
    mem_write_b = 1'b1; mem_address_b = 16'h0600; mem_wdata_b = 16'h9999; mem_wmask_b = 2'b00;
    step();
    check("M0 c1 write", pmem_write, 1'b1);
    check("M0 c1 wmask", pmem_wmask, 2'b00);
    idle_inputs();
    step();
    check("M0 c2 resp", {mem_resp_a, mem_resp_b}, 2'b01);
    step();
    check("M0 c3 resp", {mem_resp_a, mem_resp_b}, 2'b00);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_port_responder.md
# mem_port_responder

Memory-side responder for the pipeline's two memory ports: port A (instruction fetch, read-only) and port B (data, read/write with byte mask). Serialises both requests onto one physical memory interface (pmem) and returns a single joint response cycle so the pipeline's stage registers can advance on one edge. Sits between the pipelined datapath and the cache/physical memory.

## Interface
- DATA_W, 16, data word width (lc3b_word)
- ADDR_W, 16, byte address width
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- mem_read_a  in  1  port A read request, held until mem_resp_a
- mem_address_a  in  ADDR_W  port A address
- mem_resp_a  out  1  port A done, one-cycle pulse
- mem_rdata_a  out  DATA_W  port A read data, valid while mem_resp_a high, held after
- mem_read_b  in  1  port B read request
- mem_write_b  in  1  port B write request
- mem_wmask_b  in  2  port B byte enables ([0] low byte, [1] high byte)
- mem_address_b  in  ADDR_W  port B address
- mem_wdata_b  in  DATA_W  port B write data
- mem_resp_b  out  1  port B done, one-cycle pulse
- mem_rdata_b  out  DATA_W  port B read data, valid while mem_resp_b high, held after
- pmem_read  out  1  physical read strobe
- pmem_write  out  1  physical write strobe
- pmem_wmask  out  2  physical byte enables
- pmem_address  out  ADDR_W  physical address
- pmem_wdata  out  DATA_W  physical write data
- pmem_resp  in  1  physical access complete (sampled only while a strobe is driven)
- pmem_rdata  in  DATA_W  physical read data, valid with pmem_resp

## Operation
- States: IDLE, B_ACCESS, A_ACCESS, RESPOND.
- IDLE: sample req_a = mem_read_a, req_b = mem_read_b | mem_write_b. Latch need_a, need_b, address_a, address_b, wdata_b, wmask_b, op_b (write if mem_write_b, else read; write wins if both asserted). Next: B_ACCESS if req_b, else A_ACCESS if req_a, else IDLE.
- B_ACCESS: pmem_read = !op_b, pmem_write = op_b, pmem_address = address_b, pmem_wdata = wdata_b, pmem_wmask = op_b ? wmask_b : 2'b11. On pmem_resp: if read, mem_rdata_b <= pmem_rdata; next A_ACCESS if need_a, else RESPOND.
- A_ACCESS: pmem_read = 1, pmem_address = address_a, pmem_wmask = 2'b11. On pmem_resp: mem_rdata_a <= pmem_rdata; next RESPOND.
- RESPOND: mem_resp_a = need_a, mem_resp_b = need_b for exactly one cycle; next IDLE.
- Port B is always served before port A (data access is older in program order).
- Outside B_ACCESS/A_ACCESS all pmem outputs are 0; pmem_resp ignored.
- Requests changing after latch are ignored until the next IDLE sample.
- mem_wmask_b = 2'b00 on a write is still issued as a pmem write (mask passed through).

## Timing
- Reset (async assert): state IDLE; need_a/need_b 0; mem_resp_a/b 0; mem_rdata_a/b 0; all pmem outputs 0. Reset mid-access abandons the access immediately; no response issued.
- Latency, pmem_resp in first access cycle: A-only or B-only request seen in IDLE cycle 0 -> strobe cycle 1 -> resp cycle 2. A+B -> B strobe cycle 1, A strobe cycle 2, both resps cycle 3.
- Each extra pmem wait cycle adds one cycle; strobes and address stay constant while waiting.
- mem_resp_a and mem_resp_b, when both requested, rise and fall on the same edges.
- After RESPOND, at least one IDLE cycle before the next pmem strobe; a request still high in that IDLE cycle is accepted as a new request.
- mem_rdata_a/b change only on the pmem_resp edge of their own access.

## Test plan
- Reset: hold rst_n low mid-B_ACCESS with pmem_read high -> all outputs 0 asynchronously, state IDLE after release, no mem_resp pulse.
- A-only read, addr 0x0040, pmem_rdata 0x1234 with zero-wait pmem -> pmem_read in cycle 1 only, mem_resp_a high cycle 2 with mem_rdata_a 0x1234, mem_resp_b low.
- Simultaneous A read 0x0010 + B read 0x2000, pmem returns 0xBEEF then 0x00AA, 2 wait cycles each -> B address issued first, both resps in one cycle, mem_rdata_b 0xBEEF, mem_rdata_a 0x00AA.
- B write 0x3002, wdata 0x5A5A, wmask 2'b10, plus A read -> pmem_write with wmask 2'b10, then pmem_read wmask 2'b11, mem_rdata_b unchanged, joint resp.
- mem_read_b and mem_write_b both high -> only pmem_write issued; address_a changed during B_ACCESS -> original latched address used for A.
- Back-to-back: requests held through RESPOND -> one IDLE cycle then new transaction; pmem_resp pulsed in IDLE -> ignored.
